// File: rtl/lzrw1_pkg.sv
// Shared LZRW1 definitions: item-kind encodings and the stream unpacker state set.
// Used by lzrw1_item_unpacker and decompressor_top.
package lzrw1_pkg;

    localparam int   CW_BITS_PER_BYTE = 8;
    localparam logic ITEM_COPY        = 1'b1;
    localparam logic ITEM_LITERAL     = 1'b0;

    typedef enum logic [2:0] {
        S_CW,
        S_ITEM_HI,
        S_ITEM_LO,
        S_EMIT,
        S_END
    } unpack_state_t;

endpackage

// File: rtl/lzrw1_flag_shifter.sv
// Control-word flag register: control bytes load MSB-first, the current flag is the MSB,
// and each accepted item shifts the next flag into place.
module lzrw1_flag_shifter
    import lzrw1_pkg::*;
#(
    parameter int CW_BYTES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       shift,
    output logic       flag,
    output logic       exhausted
);

    localparam int FLAG_BITS = CW_BITS_PER_BYTE * CW_BYTES;
    localparam int IDX_W     = (FLAG_BITS > 1) ? $clog2(FLAG_BITS) : 1;

    logic [FLAG_BITS-1:0] flags_q, flags_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        flags_d = flags_q;
        idx_d   = idx_q;
        if (load) begin
            flags_d = (flags_q << CW_BITS_PER_BYTE) | FLAG_BITS'(load_byte);
            idx_d   = '0;
        end else if (shift) begin
            flags_d = flags_q << 1;
            idx_d   = idx_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
            idx_q   <= '0;
        end else begin
            flags_q <= flags_d;
            idx_q   <= idx_d;
        end
    end

    assign flag      = flags_q[FLAG_BITS-1];
    assign exhausted = (idx_q == IDX_W'(FLAG_BITS - 1));

endmodule

// File: rtl/lzrw1_item_unpacker.sv
// Splits a raw LZRW1 byte stream into flagged 16-bit items and holds each one
// until the downstream decompressor is not busy.
module lzrw1_item_unpacker
    import lzrw1_pkg::*;
#(
    parameter int CW_BYTES    = 2,
    parameter int COUNT_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [15:0]            data_out,
    output logic                   control_word_out,
    output logic                   out_valid,
    input  logic                   decompressor_busy,
    output logic                   stream_done,
    output logic                   format_error,
    output logic [COUNT_WIDTH-1:0] item_count
);

    localparam int CW_CNT_W = (CW_BYTES > 1) ? $clog2(CW_BYTES) : 1;

    unpack_state_t          state_q, state_d;
    logic [CW_CNT_W-1:0]    cw_cnt_q, cw_cnt_d;
    logic                   new_stream_q, new_stream_d;
    logic [7:0]             hi_byte_q, hi_byte_d;
    logic                   last_item_q, last_item_d;
    logic [15:0]            data_q, data_d;
    logic                   cw_q, cw_d;
    logic                   out_valid_q, out_valid_d;
    logic                   stream_done_q, stream_done_d;
    logic                   format_error_q, format_error_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic load_flags, shift_flags, cur_flag, flags_exhausted;

    lzrw1_flag_shifter #(
        .CW_BYTES (CW_BYTES)
    ) u_flags (
        .clock     (clock),
        .reset     (reset),
        .load      (load_flags),
        .load_byte (in_byte),
        .shift     (shift_flags),
        .flag      (cur_flag),
        .exhausted (flags_exhausted)
    );

    always_comb begin
        state_d        = state_q;
        cw_cnt_d       = cw_cnt_q;
        new_stream_d   = new_stream_q;
        hi_byte_d      = hi_byte_q;
        last_item_d    = last_item_q;
        data_d         = data_q;
        cw_d           = cw_q;
        count_d        = count_q;
        format_error_d = 1'b0;
        load_flags     = 1'b0;
        shift_flags    = 1'b0;

        unique case (state_q)
            S_CW: if (in_valid) begin
                load_flags = 1'b1;
                if (new_stream_q) begin
                    count_d      = '0;
                    new_stream_d = 1'b0;
                end
                if (in_last) begin
                    state_d  = S_END;
                    cw_cnt_d = '0;
                end else if (cw_cnt_q == CW_CNT_W'(CW_BYTES - 1)) begin
                    state_d  = S_ITEM_HI;
                    cw_cnt_d = '0;
                end else begin
                    cw_cnt_d = cw_cnt_q + 1'b1;
                end
            end
            S_ITEM_HI: if (in_valid) begin
                hi_byte_d = in_byte;
                if (cur_flag == ITEM_COPY) begin
                    // A stream ending halfway through a copy item is dropped and flagged.
                    if (in_last) begin
                        state_d        = S_END;
                        format_error_d = 1'b1;
                    end else begin
                        state_d = S_ITEM_LO;
                    end
                end else begin
                    data_d      = {8'h00, in_byte};
                    cw_d        = ITEM_LITERAL;
                    last_item_d = in_last;
                    state_d     = S_EMIT;
                end
            end
            S_ITEM_LO: if (in_valid) begin
                data_d      = {hi_byte_q, in_byte};
                cw_d        = ITEM_COPY;
                last_item_d = in_last;
                state_d     = S_EMIT;
            end
            S_EMIT: if (!decompressor_busy) begin
                shift_flags = 1'b1;
                if (count_q != '1) count_d = count_q + 1'b1;
                if (last_item_q)          state_d = S_END;
                else if (flags_exhausted) state_d = S_CW;
                else                      state_d = S_ITEM_HI;
            end
            S_END: begin
                new_stream_d = 1'b1;
                state_d      = S_CW;
            end
            default: state_d = S_CW;
        endcase

        out_valid_d   = (state_d == S_EMIT);
        stream_done_d = (state_d == S_END);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_CW;
            cw_cnt_q       <= '0;
            new_stream_q   <= 1'b1;
            hi_byte_q      <= '0;
            last_item_q    <= 1'b0;
            data_q         <= '0;
            cw_q           <= 1'b0;
            out_valid_q    <= 1'b0;
            stream_done_q  <= 1'b0;
            format_error_q <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            cw_cnt_q       <= cw_cnt_d;
            new_stream_q   <= new_stream_d;
            hi_byte_q      <= hi_byte_d;
            last_item_q    <= last_item_d;
            data_q         <= data_d;
            cw_q           <= cw_d;
            out_valid_q    <= out_valid_d;
            stream_done_q  <= stream_done_d;
            format_error_q <= format_error_d;
            count_q        <= count_d;
        end
    end

    // Gated by reset so the port is low during reset yet high the instant reset releases.
    assign in_ready = reset && (state_q inside {S_CW, S_ITEM_HI, S_ITEM_LO});

    assign data_out         = data_q;
    assign control_word_out = cw_q;
    assign out_valid        = out_valid_q;
    assign stream_done      = stream_done_q;
    assign format_error     = format_error_q;
    assign item_count       = count_q;

endmodule

// File: tb/tb_lzrw1_item_unpacker.sv
// Directed bench for lzrw1_item_unpacker: parsing, group wrap, backpressure,
// truncation, mid-item reset and an empty stream.
module tb_lzrw1_item_unpacker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] data_out;
    logic        control_word_out;
    logic        out_valid;
    logic        decompressor_busy = 1'b0;
    logic        stream_done;
    logic        format_error;
    logic [11:0] item_count;

    int total = 0;
    int bad   = 0;

    logic [16:0] items[$];
    int          valid_seen = 0;

    lzrw1_item_unpacker #(
        .CW_BYTES    (2),
        .COUNT_WIDTH (12)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .in_byte           (in_byte),
        .in_valid          (in_valid),
        .in_last           (in_last),
        .in_ready          (in_ready),
        .data_out          (data_out),
        .control_word_out  (control_word_out),
        .out_valid         (out_valid),
        .decompressor_busy (decompressor_busy),
        .stream_done       (stream_done),
        .format_error      (format_error),
        .item_count        (item_count)
    );

    always #5 clock = ~clock;

    // Items are recorded half a cycle before the edge that accepts them.
    always @(negedge clock) begin
        if (reset && out_valid) begin
            valid_seen++;
            if (!decompressor_busy) items.push_back({control_word_out, data_out});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("send_timeout", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (stream_done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("done_seen", {31'd0, stream_done}, 32'd1);
    endtask

    function automatic logic [16:0] item_at(input int i);
        if (i < items.size()) return items[i];
        return 17'h1ffff;
    endfunction

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, data_out}, 32'd0);
        check("rst_count", {20'd0, item_count}, 32'd0);
        check("rst_done", {31'd0, stream_done}, 32'd0);
        reset = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);
        step();

        // Test 1: copy then literal
        items.delete();
        send_byte(8'h80, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        check("t1_valid_rise", {31'd0, out_valid}, 32'd1);
        check("t1_data_early", {16'd0, data_out}, 32'h1234);
        check("t1_ready_low", {31'd0, in_ready}, 32'd0);
        send_byte(8'h41, 1'b1);
        wait_done();
        check("t1_count", {20'd0, item_count}, 32'd2);
        check("t1_no_ferr", {31'd0, format_error}, 32'd0);
        check("t1_n_items", items.size(), 32'd2);
        check("t1_item0", {15'd0, item_at(0)}, {15'd0, 1'b1, 16'h1234});
        check("t1_item1", {15'd0, item_at(1)}, {15'd0, 1'b0, 16'h0041});
        step();
        check("t1_done_pulse", {31'd0, stream_done}, 32'd0);

        // Test 2: a full literal group, then a wrap into a second group with a copy
        items.delete();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h41 + i), 1'b0);
        send_byte(8'hC0, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b1);
        wait_done();
        check("t2_count", {20'd0, item_count}, 32'd17);
        check("t2_n_items", items.size(), 32'd17);
        for (int i = 0; i < 16; i++)
            check($sformatf("t2_lit%0d", i), {15'd0, item_at(i)}, {15'd0, 1'b0, 8'h00, 8'(8'h41 + i)});
        check("t2_copy", {15'd0, item_at(16)}, {15'd0, 1'b1, 16'hABCD});
        step();

        // Test 3: backpressure holds the copy item
        items.delete();
        decompressor_busy = 1'b1;
        send_byte(8'h80, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_valid%0d", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("t3_data%0d", i), {15'd0, control_word_out, data_out}, {15'd0, 1'b1, 16'h1234});
            check($sformatf("t3_ready%0d", i), {31'd0, in_ready}, 32'd0);
            step();
        end
        decompressor_busy = 1'b0;
        send_byte(8'h41, 1'b1);
        wait_done();
        check("t3_n_items", items.size(), 32'd2);
        check("t3_item0", {15'd0, item_at(0)}, {15'd0, 1'b1, 16'h1234});
        check("t3_count", {20'd0, item_count}, 32'd2);
        step();

        // Test 4: stream truncated inside a copy item, then a normal stream
        items.delete();
        valid_seen = 0;
        send_byte(8'h80, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h12, 1'b1);
        check("t4_done", {31'd0, stream_done}, 32'd1);
        check("t4_ferr", {31'd0, format_error}, 32'd1);
        check("t4_no_valid", valid_seen, 32'd0);
        step();
        check("t4_ferr_pulse", {31'd0, format_error}, 32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h41, 1'b1);
        wait_done();
        check("t4_next_items", items.size(), 32'd1);
        check("t4_next_item", {15'd0, item_at(0)}, {15'd0, 1'b0, 16'h0041});
        check("t4_next_ferr", {31'd0, format_error}, 32'd0);
        step();

        // Test 5: reset while the second copy byte is pending
        items.delete();
        send_byte(8'h80, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h12, 1'b0);
        reset = 1'b0;
        #1;
        check("t5_ready", {31'd0, in_ready}, 32'd0);
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_data", {16'd0, data_out}, 32'd0);
        check("t5_cw", {31'd0, control_word_out}, 32'd0);
        check("t5_count", {20'd0, item_count}, 32'd0);
        step();
        reset = 1'b1;
        #1;
        check("t5_ready_rel", {31'd0, in_ready}, 32'd1);
        step();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h41, 1'b1);
        wait_done();
        check("t5_n_items", items.size(), 32'd1);
        check("t5_item", {15'd0, item_at(0)}, {15'd0, 1'b0, 16'h0041});
        check("t5_count_after", {20'd0, item_count}, 32'd1);
        step();

        // Test 6: empty stream terminated on a control byte
        items.delete();
        send_byte(8'h00, 1'b1);
        check("t6_done", {31'd0, stream_done}, 32'd1);
        check("t6_count", {20'd0, item_count}, 32'd0);
        check("t6_ferr", {31'd0, format_error}, 32'd0);
        step();
        check("t6_done_pulse", {31'd0, stream_done}, 32'd0);
        check("t6_no_items", items.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lzrw1_item_unpacker.md
# lzrw1_item_unpacker

Upstream feeder for `decompressor_top`. Accepts a raw LZRW1 compressed byte stream and splits it into control-word flag bits and items. Presents each item as a 16-bit `data_out` with its flag bit on `control_word_out`. Holds each item until the decompressor is not busy, which replaces the bench-driven item sequencing with synthesizable logic.

## Interface
Parameters:
- `CW_BYTES`, 2: control-word bytes per group. There are 8·`CW_BYTES` flag bits per group.
- `COUNT_WIDTH`, 12: width of the item counter, sized for 4096-byte streams.

Ports:
- `clock`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-low reset.
- `in_byte`  in  8  compressed stream byte.
- `in_valid`  in  1  `in_byte` is valid.
- `in_last`  in  1  qualifies the final byte of a stream.
- `in_ready`  out  1  byte accepted on the rising edge where `in_valid && in_ready`.
- `data_out`  out  16  item. A copy item is {byte0, byte1}. A literal is {8'h00, byte}.
- `control_word_out`  out  1  1 = copy item (2 bytes), 0 = literal (1 byte).
- `out_valid`  out  1  item presented. Maps to decompressor `data_in_valid`.
- `decompressor_busy`  in  1  while high, a presented item is not accepted.
- `stream_done`  out  1  one-cycle pulse after the last item of a stream is accepted.
- `format_error`  out  1  one-cycle pulse, coincident with `stream_done`, when a stream is truncated.
- `item_count`  out  COUNT_WIDTH  items accepted in the current stream. Saturates at all-ones.

## Operation
- States:
  - S_CW: collect control bytes into a flag shift register. The first byte supplies flags 0–7, MSB first.
  - S_ITEM_HI: capture the first item byte.
  - S_ITEM_LO: capture the second byte of a copy item.
  - S_EMIT: present the item.
  - S_END: issue the `stream_done` pulse.
- S_CW:
  - Accepts `CW_BYTES` bytes, then goes to S_ITEM_HI with flag index 0.
  - Accepting the first S_CW byte of a new stream clears `item_count`.
- S_ITEM_HI: on byte accept, go to S_ITEM_LO if the current flag is 1, else go to S_EMIT.
- S_ITEM_LO: on byte accept, go to S_EMIT.
- S_EMIT:
  - `out_valid` = 1. The item is accepted on the edge where `!decompressor_busy`.
  - `item_count` increments on acceptance.
  - Next state after acceptance:
    - S_END if the item's last byte carried `in_last`.
    - S_CW if the flag index reached 8·`CW_BYTES`−1.
    - Otherwise S_ITEM_HI with the flag index incremented.
- S_END: pulses `stream_done`, then goes to S_CW.
- `in_ready` = 1 exactly in S_CW, S_ITEM_HI and S_ITEM_LO.
- Boundaries:
  - `in_last` on any S_CW byte goes to S_END. No items are emitted; unused flags are discarded.
  - `in_last` on the first byte of a copy item goes to S_END with `format_error` = 1. The partial item is discarded and `out_valid` is never raised for it.
  - Unused flag bits in the last group are ignored.
  - `in_valid` low stalls the FSM in its state. `in_last` without `in_valid` is ignored.
  - `decompressor_busy` high for any number of cycles holds `data_out`/`control_word_out` stable and `out_valid` high.
- Reset (asynchronous, any state):
  - State → S_CW.
  - Flags, index, `data_out` → 0; `control_word_out`, `out_valid`, `in_ready` → 0 while asserted; `stream_done`, `format_error` → 0; `item_count` → 0.
  - A partial item is discarded.

## Timing
- Byte capture: one byte per cycle maximum.
- Literal: 2 cycles from byte accept to earliest item accept (capture edge, then emit edge).
- Copy: 3 cycles.
- `out_valid` rises the cycle after the item's last byte is accepted.
- Downstream acceptance edge: `in_ready` rises the following cycle.
- `stream_done` is high the cycle after the final item is accepted, or the cycle after an `in_last` S_CW byte is accepted.
- `in_ready` is 1 in the first cycle after reset deasserts.

## Structure
- `lzrw1_pkg`:
  - `unpack_state_t` enum.
  - `CW_BITS_PER_BYTE` = 8.
  - `ITEM_COPY` = 1'b1.
  - `ITEM_LITERAL` = 1'b0.
  - Shared with `decompressor_top`.
- Sub-module `lzrw1_flag_shifter`: loads control bytes MSB-first, exposes the current flag and a "group exhausted" signal, and shifts on item accept.
- The remainder is a single FSM.

## Test plan
- Bytes 0x80,0x00,0x12,0x34,0x41(last), `decompressor_busy`=0.
  - Item 1: {16'h1234, cw=1}.
  - Item 2: {16'h0041, cw=0}.
  - Then `stream_done` pulse and `item_count`=2.
- Flags 0x00,0x00 followed by 16 literals 0x41..0x50, then control bytes 0xC0,0x00, then copy 0xAB,0xCD(last).
  - 16 literals emitted, the 17th item is {16'hABCD, cw=1}.
  - Verifies group wrap.
- Hold `decompressor_busy`=1 for 5 cycles during item 1 of test 1.
  - `out_valid` and `data_out`=16'h1234 remain stable.
  - `in_ready`=0 throughout.
  - Exactly one acceptance occurs.
- Bytes 0x80,0x00,0x12(last).
  - No `out_valid`.
  - `stream_done` and `format_error` pulse together.
  - Next stream parses normally.
- Assert reset low during S_ITEM_LO of test 1.
  - All outputs return to reset values.
  - A following 0x00,0x00,0x41(last) yields {16'h0041, cw=0} and `item_count`=1.
- Byte 0x00(last) in S_CW.
  - `stream_done` the next cycle, no items, `item_count`=0.
